mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 The block SHALL have these ports, one per line as name, direction, width and meaning:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- if_req  in  1  fetch request; held until if_valid.
- if_addr  in  32  fetch byte address.
- if_rdata  out  32  fetched word.
- if_valid  out  1  one-cycle fetch completion pulse.
- d_read  in  3  load code: 000 off, 001 LW, 010 LH, 011 LHU, 100 LB, 101 LBU.
- d_write  in  2  store code: 00 off, 01 SW, 10 SH, 11 SB.
- d_addr  in  32  data byte address.
- d_wdata  in  32  store data.
- d_rdata  out  32  load result.
- d_valid  out  1  one-cycle data completion pulse (loads and stores).
- stall  out  1  pipeline stall: a request is pending and not completing this cycle.
- mem_read  out  3  to memory, load code.
- mem_write  out  2  to memory, store code.
- mem_addr  out  32  to memory, address.
- mem_wdata  out  32  to memory, store data.
- mem_rdata  in  32  from memory, combinational read data.

REQ-002 A data request SHALL be defined as d_read != 000 or d_write != 00.

Function
REQ-003 The FSM SHALL have exactly the states IDLE, GRANT_I, GRANT_D and RESP.
REQ-004 In IDLE, or on leaving RESP, the FSM SHALL go to GRANT_D if only a data request is pending, to GRANT_I if only if_req is pending, and otherwise stay in or return to IDLE.
REQ-005 On simultaneous requests, the FSM SHALL grant the requester not named by the last_grant pointer; after reset last_grant = I, so data wins first.
REQ-006 In GRANT_I the outputs SHALL be mem_read=001, mem_write=00, mem_addr=if_addr; mem_rdata SHALL be captured into if_rdata at the edge ending the state.
REQ-007 In GRANT_D with a store code, the outputs SHALL be mem_write=d_write, mem_read=000, mem_addr=d_addr, mem_wdata=d_wdata.
REQ-008 In GRANT_D with a load code only, the outputs SHALL be mem_read=d_read, mem_write=00; mem_rdata SHALL be captured into d_rdata.
REQ-009 In GRANT_D, when both a load code and a store code are present, the store SHALL execute and the load code SHALL be ignored.
REQ-010 Outside the GRANT states, mem_read SHALL be 000, mem_write SHALL be 00, and mem_addr/mem_wdata SHALL hold their last value.
REQ-011 Each GRANT state SHALL last exactly one cycle and SHALL then go to RESP, updating last_grant.
REQ-012 In RESP, the matching valid SHALL be high for exactly one cycle and if_rdata/d_rdata SHALL be stable.
REQ-013 Latency SHALL be request sampled in cycle N, grant in N+1, valid in N+2; back-to-back throughput SHALL be one transaction per 2 cycles.
REQ-014 In RESP, the just-served requester's request SHALL be ignored for the next arbitration, so a held-high req is not re-granted.
REQ-015 if_rdata and d_rdata SHALL hold their value until the next capture.
REQ-016 stall SHALL equal (if_req and not if_valid) or (data request and not d_valid).
REQ-017 Request inputs SHALL be sampled only in IDLE and RESP; changes during GRANT SHALL NOT alter the current transaction.

Reset
REQ-018 Asserting rst SHALL immediately force: state IDLE, last_grant=I, if_valid=0, d_valid=0, if_rdata=0, d_rdata=0, mem_read=000, mem_write=00, mem_addr=0, mem_wdata=0.
REQ-019 Reset asserted during GRANT_D SHALL suppress the store, since mem_write is 00 at the next edge; the in-flight transaction SHALL be dropped without a valid pulse.
REQ-020 After rst deasserts, the first edge SHALL sample requests from IDLE.

Structure
REQ-021 Package riscv_mem_pkg SHALL hold the FSM state enum, the load codes (LD_OFF, LW, LH, LHU, LB, LBU) and the store codes (ST_OFF, SW, SH, SB); the memory module shares these.
REQ-022 The block SHALL be a single module with no sub-module; the round-robin pick SHALL be inline logic.

Verification
REQ-023 The bench SHALL cover these directed scenarios, stimulus -> required response:
- Reset, then if_req=1, if_addr=0x10, memory word 4 = 0xDEADBEEF -> mem_read=001 in cycle 1; if_valid=1 and if_rdata=0xDEADBEEF in cycle 2; stall=1 in cycles 0-1.
- if_req and d_read=001 (d_addr=0x20) both raised in the same cycle after reset -> data granted first, d_valid in cycle 2; fetch granted in cycle 3, if_valid in cycle 4.
- Both requests held continuously for 8 cycles -> grants alternate D,I,D,I; each valid pulses one cycle; neither requester starves.
- d_write=01, d_addr=0x08, d_wdata=0x12345678, then d_read=100 at 0x08 -> first d_valid with memory word 2 = 0x12345678; second d_rdata=0x00000078.
- d_read=001 and d_write=11 together -> mem_write=11, mem_read=000; d_valid pulses once.
- rst pulsed mid-cycle during GRANT_D with a store -> memory word unchanged, no d_valid, state IDLE; outputs at reset values before the next edge.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the single-port memory arbiter and the memory behind it:
// arbiter FSM states, load codes, store codes and a data-request helper.
package riscv_mem_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    GRANT_I = 2'b01,
    GRANT_D = 2'b10,
    RESP    = 2'b11
  } arb_state_t;

  localparam logic [2:0] LD_OFF = 3'b000;
  localparam logic [2:0] LW     = 3'b001;
  localparam logic [2:0] LH     = 3'b010;
  localparam logic [2:0] LHU    = 3'b011;
  localparam logic [2:0] LB     = 3'b100;
  localparam logic [2:0] LBU    = 3'b101;

  localparam logic [1:0] ST_OFF = 2'b00;
  localparam logic [1:0] SW     = 2'b01;
  localparam logic [1:0] SH     = 2'b10;
  localparam logic [1:0] SB     = 2'b11;

  // A data request is any load or store code other than "off".
  function automatic logic is_data_req(input logic [2:0] rd, input logic [1:0] wr);
    return (rd != LD_OFF) || (wr != ST_OFF);
  endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates one memory port between instruction fetch and data load/store.
// Each transaction takes a one-cycle GRANT followed by a one-cycle RESP that
// carries the valid pulse; simultaneous requests alternate via last_grant.
module mem_port_arbiter
  import riscv_mem_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_valid,
  input  logic [2:0]  d_read,
  input  logic [1:0]  d_write,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_valid,
  output logic        stall,
  output logic [2:0]  mem_read,
  output logic [1:0]  mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  arb_state_t  r_state;
  logic        r_last_grant_d;   // 1: data was served last, 0: fetch was served last
  logic        r_if_valid;
  logic        r_d_valid;
  logic [31:0] r_if_rdata;
  logic [31:0] r_d_rdata;
  logic [2:0]  r_mem_read;
  logic [1:0]  r_mem_write;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_wdata;

  logic w_d_req;
  logic w_served_i;
  logic w_served_d;
  logic w_if_pend;
  logic w_d_pend;
  logic w_pick_d;
  logic w_pick_i;

  // In RESP the requester just served is masked so a held request is not re-granted.
  assign w_d_req    = is_data_req(d_read, d_write);
  assign w_served_i = (r_state == RESP) && !r_last_grant_d;
  assign w_served_d = (r_state == RESP) &&  r_last_grant_d;
  assign w_if_pend  = if_req  && !w_served_i;
  assign w_d_pend   = w_d_req && !w_served_d;
  // Round-robin pick: on a tie, grant whoever was not served last.
  assign w_pick_d   = w_d_pend && (!w_if_pend || !r_last_grant_d);
  assign w_pick_i   = w_if_pend && !w_pick_d;

  // Arbiter FSM with registered memory-port controls, valids and read data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= IDLE;
      r_last_grant_d <= 1'b0;
      r_if_valid     <= 1'b0;
      r_d_valid      <= 1'b0;
      r_if_rdata     <= 32'h0000_0000;
      r_d_rdata      <= 32'h0000_0000;
      r_mem_read     <= LD_OFF;
      r_mem_write    <= ST_OFF;
      r_mem_addr     <= 32'h0000_0000;
      r_mem_wdata    <= 32'h0000_0000;
    end else begin
      r_if_valid  <= 1'b0;
      r_d_valid   <= 1'b0;
      r_mem_read  <= LD_OFF;
      r_mem_write <= ST_OFF;
      case (r_state)
        IDLE, RESP: begin
          if (w_pick_d) begin
            r_state    <= GRANT_D;
            r_mem_addr <= d_addr;
            if (d_write != ST_OFF) begin
              // A store wins over any load code presented with it.
              r_mem_write <= d_write;
              r_mem_wdata <= d_wdata;
            end else begin
              r_mem_read <= d_read;
            end
          end else if (w_pick_i) begin
            r_state    <= GRANT_I;
            r_mem_read <= LW;
            r_mem_addr <= if_addr;
          end else begin
            r_state <= IDLE;
          end
        end
        GRANT_I: begin
          r_if_rdata     <= mem_rdata;
          r_if_valid     <= 1'b1;
          r_last_grant_d <= 1'b0;
          r_state        <= RESP;
        end
        GRANT_D: begin
          if (r_mem_write == ST_OFF) begin
            r_d_rdata <= mem_rdata;
          end else begin
            r_d_rdata <= r_d_rdata;
          end
          r_d_valid      <= 1'b1;
          r_last_grant_d <= 1'b1;
          r_state        <= RESP;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign if_rdata  = r_if_rdata;
  assign if_valid  = r_if_valid;
  assign d_rdata   = r_d_rdata;
  assign d_valid   = r_d_valid;
  assign mem_read  = r_mem_read;
  assign mem_write = r_mem_write;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign stall     = (if_req && !r_if_valid) || (w_d_req && !r_d_valid);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter with a small byte-lane memory model.
module tb_mem_port_arbiter;
  import riscv_mem_pkg::*;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_valid;
  logic [2:0]  d_read;
  logic [1:0]  d_write;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_valid;
  logic        stall;
  logic [2:0]  mem_read;
  logic [1:0]  mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic [31:0] mem [0:63];
  logic        tb_init;
  logic [31:0] exp_if[$];
  logic [31:0] exp_d[$];
  int          n_vec;
  int          n_miscmp;
  logic        prev_if_valid;
  logic        prev_d_valid;

  mem_port_arbiter dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_valid(d_valid), .stall(stall),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] init_word(input int i);
    case (i)
      3:       return 32'h1122_3344;
      4:       return 32'hDEAD_BEEF;
      5:       return 32'h5555_5555;
      8:       return 32'hCAFE_F00D;
      default: return 32'h0000_0000;
    endcase
  endfunction

  // Memory read path: combinational, with load-size extraction.
  always_comb begin
    logic [31:0] w;
    logic [15:0] h;
    logic [7:0]  b;
    w = mem[mem_addr[7:2]];
    h = mem_addr[1] ? w[31:16] : w[15:0];
    b = w[8*mem_addr[1:0] +: 8];
    case (mem_read)
      LH:      mem_rdata = {{16{h[15]}}, h};
      LHU:     mem_rdata = {16'h0000, h};
      LB:      mem_rdata = {{24{b[7]}}, b};
      LBU:     mem_rdata = {24'h00_0000, b};
      default: mem_rdata = w;
    endcase
  end

  // Memory write path: preload while tb_init, otherwise byte-lane stores.
  always @(posedge clk) begin
    if (tb_init) begin
      for (int i = 0; i < 64; i++) mem[i] <= init_word(i);
    end else begin
      case (mem_write)
        SW: mem[mem_addr[7:2]] <= mem_wdata;
        SH: mem[mem_addr[7:2]][16*mem_addr[1] +: 16] <= mem_wdata[15:0];
        SB: mem[mem_addr[7:2]][8*mem_addr[1:0] +: 8] <= mem_wdata[7:0];
        default: ;
      endcase
    end
  end

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miscmp++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every valid pulse pops and compares its expected read data.
  always @(negedge clk) begin
    if (!rst) begin
      if (if_valid) begin
        if (exp_if.size() == 0) check_vec("if_unexpected", 32'd1, 32'd0);
        else check_vec("if_rdata", if_rdata, exp_if.pop_front());
        if (prev_if_valid) check_vec("if_pulse_len", 32'd2, 32'd1);
      end
      if (d_valid) begin
        if (exp_d.size() == 0) check_vec("d_unexpected", 32'd1, 32'd0);
        else check_vec("d_rdata", d_rdata, exp_d.pop_front());
        if (prev_d_valid) check_vec("d_pulse_len", 32'd2, 32'd1);
      end
    end
    prev_if_valid = if_valid;
    prev_d_valid  = d_valid;
  end

  initial begin
    n_vec = 0; n_miscmp = 0;
    prev_if_valid = 1'b0; prev_d_valid = 1'b0;
    rst = 1'b1; tb_init = 1'b1;
    if_req = 1'b0; if_addr = 32'h0; d_read = LD_OFF; d_write = ST_OFF;
    d_addr = 32'h0; d_wdata = 32'h0;
    next(); next();
    @(negedge clk);
    check_vec("rst_if_valid", 32'(if_valid), 32'd0);
    check_vec("rst_d_valid", 32'(d_valid), 32'd0);
    check_vec("rst_if_rdata", if_rdata, 32'h0);
    check_vec("rst_d_rdata", d_rdata, 32'h0);
    check_vec("rst_mem_ctl", {27'h0, mem_read, mem_write}, 32'h0);
    check_vec("rst_mem_addr", mem_addr, 32'h0);
    check_vec("rst_mem_wdata", mem_wdata, 32'h0);
    next(); rst = 1'b0; tb_init = 1'b0;

    // Fetch alone: grant in cycle 1, valid in cycle 2.
    next(); if_req = 1'b1; if_addr = 32'h10; exp_if.push_back(32'hDEAD_BEEF);
    @(negedge clk); check_vec("s1_stall_c0", 32'(stall), 32'd1);
    next(); @(negedge clk);
    check_vec("s1_mem_read_c1", 32'(mem_read), 32'(LW));
    check_vec("s1_mem_addr_c1", mem_addr, 32'h10);
    check_vec("s1_stall_c1", 32'(stall), 32'd1);
    next(); @(negedge clk);
    check_vec("s1_if_valid_c2", 32'(if_valid), 32'd1);
    check_vec("s1_stall_c2", 32'(stall), 32'd0);
    next(); if_req = 1'b0;

    // Simultaneous fetch and load: data wins first after reset.
    next(); if_req = 1'b1; if_addr = 32'h10; d_read = LW; d_addr = 32'h20;
    exp_d.push_back(32'hCAFE_F00D); exp_if.push_back(32'hDEAD_BEEF);
    next(); @(negedge clk);
    check_vec("s2_addr_c1", mem_addr, 32'h20);
    next(); @(negedge clk);
    check_vec("s2_d_valid_c2", 32'(d_valid), 32'd1);
    check_vec("s2_if_valid_c2", 32'(if_valid), 32'd0);
    check_vec("s2_stall_c2", 32'(stall), 32'd1);
    next(); d_read = LD_OFF; @(negedge clk);
    check_vec("s2_addr_c3", mem_addr, 32'h10);
    check_vec("s2_mem_read_c3", 32'(mem_read), 32'(LW));
    next(); @(negedge clk);
    check_vec("s2_if_valid_c4", 32'(if_valid), 32'd1);
    next(); if_req = 1'b0;

    // Both held: grants alternate D,I,D,I and a fifth D is taken on the way out.
    for (int k = 0; k < 3; k++) exp_d.push_back(32'hCAFE_F00D);
    for (int k = 0; k < 2; k++) exp_if.push_back(32'hDEAD_BEEF);
    for (int c = 0; c <= 8; c++) begin
      next();
      if (c == 0) begin
        if_req = 1'b1; if_addr = 32'h10; d_read = LW; d_addr = 32'h20;
      end
      @(negedge clk);
      if ((c % 2) == 1) begin
        check_vec($sformatf("s3_grant_addr_c%0d", c), mem_addr,
                  (((c >> 1) % 2) == 0) ? 32'h20 : 32'h10);
      end else if (c > 0) begin
        check_vec($sformatf("s3_d_valid_c%0d", c), 32'(d_valid), 32'((c >> 1) % 2));
        check_vec($sformatf("s3_if_valid_c%0d", c), 32'(if_valid), 32'(1 - ((c >> 1) % 2)));
      end
    end
    next(); if_req = 1'b0; d_read = LD_OFF; @(negedge clk);
    check_vec("s3_addr_c9", mem_addr, 32'h20);
    next(); @(negedge clk);
    check_vec("s3_d_valid_c10", 32'(d_valid), 32'd1);

    // Store word, then load byte from the same address.
    next(); d_write = SW; d_addr = 32'h08; d_wdata = 32'h1234_5678;
    exp_d.push_back(32'hCAFE_F00D);
    next(); @(negedge clk);
    check_vec("s4_mem_write", 32'(mem_write), 32'(SW));
    check_vec("s4_mem_wdata", mem_wdata, 32'h1234_5678);
    next(); @(negedge clk);
    check_vec("s4_mem_word2", mem[2], 32'h1234_5678);
    next(); d_write = ST_OFF; d_read = LB; d_addr = 32'h08;
    exp_d.push_back(32'h0000_0078);
    next(); next(); d_read = LD_OFF;
    next();

    // Load and store codes together: the store executes.
    next(); d_read = LW; d_write = SB; d_addr = 32'h0C; d_wdata = 32'h0000_00A5;
    exp_d.push_back(32'h0000_0078);
    next(); @(negedge clk);
    check_vec("s5_mem_write", 32'(mem_write), 32'(SB));
    check_vec("s5_mem_read", 32'(mem_read), 32'(LD_OFF));
    next(); @(negedge clk);
    check_vec("s5_d_valid", 32'(d_valid), 32'd1);
    check_vec("s5_mem_word3", mem[3], 32'h1122_33A5);
    next(); d_read = LD_OFF; d_write = ST_OFF;
    next();

    // Reset pulsed during GRANT_D of a store: store dropped, no valid.
    next(); d_write = SW; d_addr = 32'h14; d_wdata = 32'hAAAA_AAAA;
    next(); #2 rst = 1'b1; #1;
    check_vec("s6_mem_write", 32'(mem_write), 32'(ST_OFF));
    check_vec("s6_mem_addr", mem_addr, 32'h0);
    check_vec("s6_mem_wdata", mem_wdata, 32'h0);
    check_vec("s6_d_rdata", d_rdata, 32'h0);
    check_vec("s6_state", 32'(dut.r_state), 32'(IDLE));
    next(); rst = 1'b0; d_write = ST_OFF;
    @(negedge clk);
    check_vec("s6_no_d_valid", 32'(d_valid), 32'd0);
    check_vec("s6_mem_word5", mem[5], 32'h5555_5555);
    next(); @(negedge clk);
    check_vec("s6_no_d_valid2", 32'(d_valid), 32'd0);

    // First request after reset is sampled from IDLE.
    next(); if_req = 1'b1; if_addr = 32'h10; exp_if.push_back(32'hDEAD_BEEF);
    next(); @(negedge clk);
    check_vec("s7_mem_read", 32'(mem_read), 32'(LW));
    next(); @(negedge clk);
    check_vec("s7_if_valid", 32'(if_valid), 32'd1);
    next(); if_req = 1'b0;
    next(); next();

    check_vec("sb_if_left", 32'(exp_if.size()), 32'd0);
    check_vec("sb_d_left", 32'(exp_d.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule
